// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hold/flush controller: merges per-stage hold requests into stall/bubble
// controls and turns resolve-stage traps/mispredicts into a valid/ready fetch redirect.
module pipeline_hazard_ctrl #(
    parameter int STAGES      = 5,
    parameter int HOLD_SRCS   = 4,
    parameter int REDIR_STAGE = 2,
    parameter int XLEN        = 32,
    parameter int CNT_W       = 32,
    localparam int SW         = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [HOLD_SRCS-1:0]    hold_req_i,
    input  logic [HOLD_SRCS*SW-1:0] hold_stage_i,
    input  logic                    predict_flag_i,
    input  logic                    jump_flag_i,
    input  logic [XLEN-1:0]         jump_pc_i,
    input  logic                    trap_flag_i,
    input  logic [XLEN-1:0]         trap_pc_i,
    input  logic                    redirect_ready_i,
    input  logic                    cnt_clr_i,
    output logic [STAGES-1:0]       stall_o,
    output logic [STAGES-1:0]       bubble_o,
    output logic                    redirect_valid_o,
    output logic [XLEN-1:0]         redirect_pc_o,
    output logic [CNT_W-1:0]        stall_cnt_o,
    output logic [CNT_W-1:0]        redir_cnt_o
);

    localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);

    logic            hold_any;
    logic [SW-1:0]   hold_max;
    logic [SW-1:0]   src_stage;
    logic            evt;
    logic [XLEN-1:0] evt_pc;
    logic            pending_q;
    logic            suppress_q;
    logic [XLEN-1:0] pc_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] redir_cnt_q;

    always_comb begin
        hold_any  = 1'b0;
        hold_max  = '0;
        src_stage = '0;
        for (int i = 0; i < HOLD_SRCS; i++) begin
            src_stage = hold_stage_i[i*SW +: SW];
            if (src_stage > LAST_STAGE) src_stage = LAST_STAGE;
            if (hold_req_i[i]) begin
                hold_any = 1'b1;
                if (src_stage > hold_max) hold_max = src_stage;
            end
        end
    end

    // A resolving instruction that is itself held must redirect only once.
    assign evt    = !suppress_q && (trap_flag_i || (predict_flag_i != jump_flag_i));
    assign evt_pc = trap_flag_i ? trap_pc_i : jump_pc_i;

    always_comb begin
        stall_o  = '0;
        bubble_o = '0;
        for (int k = 0; k < STAGES; k++) begin
            stall_o[k] = hold_any && (SW'(k) <= hold_max);
        end
        for (int k = 1; k < STAGES; k++) begin
            bubble_o[k] = hold_any && (SW'(k - 1) == hold_max);
        end
        for (int k = 0; k < REDIR_STAGE; k++) begin
            if (evt) begin
                stall_o[k]  = 1'b0;
                bubble_o[k] = 1'b1;
            end
        end
        if (pending_q) bubble_o[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= 1'b0;
            pc_q        <= '0;
            suppress_q  <= 1'b0;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (evt) begin
                pending_q <= 1'b1;
                pc_q      <= evt_pc;
            end else if (pending_q && redirect_ready_i) begin
                pending_q <= 1'b0;
            end

            if (!stall_o[REDIR_STAGE]) suppress_q <= 1'b0;
            else if (evt)              suppress_q <= 1'b1;

            if (cnt_clr_i)                         stall_cnt_q <= '0;
            else if (stall_o[0] && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);

            if (cnt_clr_i)                  redir_cnt_q <= '0;
            else if (evt && !(&redir_cnt_q)) redir_cnt_q <= redir_cnt_q + CNT_W'(1);
        end
    end

    assign redirect_valid_o = pending_q;
    assign redirect_pc_o    = pc_q;
    assign stall_cnt_o      = stall_cnt_q;
    assign redir_cnt_o      = redir_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: per-cycle reference model plus directed literal checks.
module tb_pipeline_hazard_ctrl;

    localparam int STAGES = 5;
    localparam int SRCS   = 4;
    localparam int RS     = 2;
    localparam int SW     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [SRCS-1:0]   hold_req;
    logic [SRCS*SW-1:0] hold_stage;
    logic              predict, jump, trap, ready, cnt_clr;
    logic [31:0]       jump_pc, trap_pc;

    logic [STAGES-1:0] stall, bubble, stall4, bubble4;
    logic              rvalid, rvalid4;
    logic [31:0]       rpc, rpc4;
    logic [31:0]       stall_cnt, redir_cnt;
    logic [3:0]        stall_cnt4, redir_cnt4;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst), .hold_req_i(hold_req), .hold_stage_i(hold_stage),
        .predict_flag_i(predict), .jump_flag_i(jump), .jump_pc_i(jump_pc),
        .trap_flag_i(trap), .trap_pc_i(trap_pc), .redirect_ready_i(ready),
        .cnt_clr_i(cnt_clr), .stall_o(stall), .bubble_o(bubble),
        .redirect_valid_o(rvalid), .redirect_pc_o(rpc),
        .stall_cnt_o(stall_cnt), .redir_cnt_o(redir_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .hold_req_i(hold_req), .hold_stage_i(hold_stage),
        .predict_flag_i(predict), .jump_flag_i(jump), .jump_pc_i(jump_pc),
        .trap_flag_i(trap), .trap_pc_i(trap_pc), .redirect_ready_i(ready),
        .cnt_clr_i(cnt_clr), .stall_o(stall4), .bubble_o(bubble4),
        .redirect_valid_o(rvalid4), .redirect_pc_o(rpc4),
        .stall_cnt_o(stall_cnt4), .redir_cnt_o(redir_cnt4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: counts are kept unbounded and saturated only when compared.
    bit          m_pend = 0, m_sup = 0;
    logic [31:0] m_pc = '0;
    longint      m_scnt = 0, m_rcnt = 0;
    bit          n_pend, n_sup;
    logic [31:0] n_pc;
    longint      n_scnt, n_rcnt;

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            int hmax;
            int e_stall, e_bubble, s;
            bit ev;
            hmax = -1;
            for (int i = 0; i < SRCS; i++) begin
                if (hold_req[i]) begin
                    s = int'(hold_stage[i*SW +: SW]);
                    if (s > STAGES - 1) s = STAGES - 1;
                    if (s > hmax) hmax = s;
                end
            end
            e_stall  = (hmax >= 0) ? ((1 << (hmax + 1)) - 1) : 0;
            e_bubble = (hmax >= 0 && hmax + 1 < STAGES) ? (1 << (hmax + 1)) : 0;
            ev = !m_sup && (trap || (predict != jump));
            if (ev) begin
                e_bubble = e_bubble | ((1 << RS) - 1);
                e_stall  = e_stall & ~((1 << RS) - 1);
            end
            if (m_pend) e_bubble = e_bubble | 1;

            check("stall_o", 64'(stall), 64'(e_stall));
            check("bubble_o", 64'(bubble), 64'(e_bubble));
            check("redirect_valid", 64'(rvalid), 64'(m_pend));
            if (m_pend) check("redirect_pc", 64'(rpc), 64'(m_pc));
            check("stall_cnt32", 64'(stall_cnt), 64'(sat(m_scnt, 64'hFFFF_FFFF)));
            check("redir_cnt32", 64'(redir_cnt), 64'(sat(m_rcnt, 64'hFFFF_FFFF)));
            check("stall_cnt4", 64'(stall_cnt4), 64'(sat(m_scnt, 15)));
            check("redir_cnt4", 64'(redir_cnt4), 64'(sat(m_rcnt, 15)));

            n_pend = m_pend; n_pc = m_pc; n_sup = m_sup; n_scnt = m_scnt; n_rcnt = m_rcnt;
            if (rst) begin
                n_pend = 0; n_pc = '0; n_sup = 0; n_scnt = 0; n_rcnt = 0;
            end else begin
                if (ev) begin
                    n_pend = 1; n_pc = trap ? trap_pc : jump_pc; n_rcnt = m_rcnt + 1;
                end else if (m_pend && ready) begin
                    n_pend = 0;
                end
                if (((e_stall >> RS) & 1) == 0) n_sup = 0;
                else if (ev) n_sup = 1;
                if (e_stall & 1) n_scnt = m_scnt + 1;
                if (cnt_clr) begin
                    n_scnt = 0; n_rcnt = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            m_pend <= n_pend; m_pc <= n_pc; m_sup <= n_sup;
            m_scnt <= n_scnt; m_rcnt <= n_rcnt;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_stage(input int src, input int v);
        hold_stage[src*SW +: SW] = SW'(v);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; hold_req = '0; hold_stage = '0; predict = 0; jump = 0; trap = 0;
        ready = 0; cnt_clr = 0; jump_pc = '0; trap_pc = '0;
        cyc();
        rst = 0; chk_en = 1;
        settle();
        check("reset stall", 64'(stall), 0);
        check("reset bubble", 64'(bubble), 0);
        check("reset valid", 64'(rvalid), 0);
        check("reset counters", 64'({stall_cnt, redir_cnt}), 0);

        // hold arbitration
        hold_req = 4'b0110; set_stage(1, 3); set_stage(2, 1);
        settle();
        check("hold stall", 64'(stall), 64'(5'b01111));
        check("hold bubble", 64'(bubble), 64'(5'b10000));
        repeat (3) cyc();
        hold_req = '0;
        settle();
        check("release stall", 64'(stall), 0);
        check("held cycles", 64'(stall_cnt), 3);
        cyc();
        hold_req = 4'b0001; set_stage(0, 7);
        settle();
        check("clamp stall", 64'(stall), 64'(5'b11111));
        check("clamp bubble", 64'(bubble), 0);
        cyc();
        set_stage(0, 0);
        settle();
        check("stage0 stall", 64'(stall), 64'(5'b00001));
        check("stage0 bubble", 64'(bubble), 64'(5'b00010));
        cyc();
        hold_req = '0;
        settle();
        check("stall cnt 5", 64'(stall_cnt), 5);

        // mispredict with immediate acceptance
        cyc();
        jump = 1; jump_pc = 32'h8000_0040; ready = 1;
        settle();
        check("mispredict flush", 64'(bubble), 64'(5'b00011));
        check("mispredict valid0", 64'(rvalid), 0);
        cyc();
        jump = 0;
        settle();
        check("redir valid", 64'(rvalid), 1);
        check("redir pc", 64'(rpc), 64'h8000_0040);
        check("redir fetch bubble", 64'(bubble), 64'(5'b00001));
        check("redir cnt 1", 64'(redir_cnt), 1);
        cyc();
        settle();
        check("accepted valid", 64'(rvalid), 0);

        // backpressure then overwrite by trap
        ready = 0; predict = 1; jump_pc = 32'h8000_0080;
        cyc();
        predict = 0;
        repeat (3) begin
            settle();
            check("bp valid", 64'(rvalid), 1);
            check("bp pc", 64'(rpc), 64'h8000_0080);
            check("bp bubble0", 64'(bubble[0]), 1);
            cyc();
        end
        trap = 1; trap_pc = 32'h8000_0100; jump = 1; jump_pc = 32'h8000_0200;
        settle();
        check("trap flush", 64'(bubble), 64'(5'b00011));
        cyc();
        trap = 0; jump = 0;
        settle();
        check("trap pc", 64'(rpc), 64'h8000_0100);
        check("trap cnt", 64'(redir_cnt), 3);
        ready = 1;
        cyc();
        settle();
        check("trap accepted", 64'(rvalid), 0);
        cyc();
        settle();
        check("no second accept", 64'(rvalid), 0);
        check("cnt after accept", 64'(redir_cnt), 3);

        // suppression while EX is held
        hold_req = 4'b1000; set_stage(3, 3); jump = 1; jump_pc = 32'h8000_0300;
        settle();
        check("supp first stall", 64'(stall), 64'(5'b01100));
        check("supp first bubble", 64'(bubble), 64'(5'b10011));
        repeat (3) begin
            cyc();
            settle();
            check("supp held stall", 64'(stall), 64'(5'b01111));
        end
        cyc();
        hold_req = '0;
        settle();
        check("supp single redirect", 64'(redir_cnt), 4);
        check("supp release bubble", 64'(bubble), 0);
        cyc();
        jump_pc = 32'h8000_0400;
        settle();
        check("post-release flush", 64'(bubble), 64'(5'b00011));
        cyc();
        jump = 0;
        settle();
        check("second redirect pc", 64'(rpc), 64'h8000_0400);
        check("second redirect cnt", 64'(redir_cnt), 5);
        cyc();

        // counter saturation and clear
        cnt_clr = 1;
        cyc();
        cnt_clr = 0;
        settle();
        check("clr stall cnt", 64'(stall_cnt), 0);
        hold_req = 4'b0100; set_stage(2, 2);
        repeat (20) cyc();
        settle();
        check("cnt32 20", 64'(stall_cnt), 20);
        check("cnt4 saturated", 64'(stall_cnt4), 64'hF);
        cnt_clr = 1;
        cyc();
        cnt_clr = 0;
        settle();
        check("clr during stall", 64'(stall_cnt), 0);
        check("clr during stall 4", 64'(stall_cnt4), 0);
        cyc();
        settle();
        check("count after clr", 64'(stall_cnt), 1);
        hold_req = '0;

        // reset mid-handshake
        ready = 0; jump = 1; jump_pc = 32'h8000_0500;
        cyc();
        jump = 0;
        settle();
        check("pending before rst", 64'(rvalid), 1);
        rst = 1;
        cyc();
        rst = 0;
        settle();
        check("rst valid", 64'(rvalid), 0);
        check("rst redir cnt", 64'(redir_cnt), 0);
        check("rst stall cnt", 64'(stall_cnt), 0);
        cyc();
        settle();
        check("no redirect after rst", 64'(rvalid), 0);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
